// File: rtl/instr_register_pkg.sv
// Shared opcode definitions for the parametrised instruction register.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    // Highest legal opcode; anything above it is flagged as illegal.
    localparam opcode_t OPC_LAST = MOD;

endpackage

// File: rtl/instr_alu.sv
// Combinational signed ALU. Operands are sign-extended to the full result
// width so that the product and the most-negative / -1 quotient both fit.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OPERAND_W = 32
) (
    input  opcode_t                        opcode,
    input  logic signed [OPERAND_W-1:0]    operand_a,
    input  logic signed [OPERAND_W-1:0]    operand_b,
    output logic signed [2*OPERAND_W-1:0]  result,
    output logic                           err
);

    localparam int RES_W = 2 * OPERAND_W;

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;

    assign a_ext = {{OPERAND_W{operand_a[OPERAND_W-1]}}, operand_a};
    assign b_ext = {{OPERAND_W{operand_b[OPERAND_W-1]}}, operand_b};

    // Opcode decode; divide-by-zero and illegal opcodes force a zero result.
    always_comb begin
        result = '0;
        err    = 1'b0;
        if (opcode > OPC_LAST) begin
            err = 1'b1;
        end else begin
            case (opcode)
                ZERO:  result = '0;
                PASSA: result = a_ext;
                PASSB: result = b_ext;
                ADD:   result = a_ext + b_ext;
                SUB:   result = a_ext - b_ext;
                MULT:  result = a_ext * b_ext;
                DIV: begin
                    if (operand_b == '0) err = 1'b1;
                    else                 result = a_ext / b_ext;
                end
                MOD: begin
                    if (operand_b == '0) err = 1'b1;
                    else                 result = a_ext % b_ext;
                end
                default: begin
                    result = '0;
                    err    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_register_param.sv
// Parametrised instruction register: two-stage write pipeline computing the
// ALU result, registered read port, per-entry valid tracking, occupancy count
// and a synchronous bulk clear.
module instr_register_param
    import instr_register_pkg::*;
#(
    parameter  int OPERAND_W = 32,
    parameter  int DEPTH     = 32,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           load_en,
    input  logic                           clear_all,
    input  opcode_t                        opcode,
    input  logic signed [OPERAND_W-1:0]    operand_a,
    input  logic signed [OPERAND_W-1:0]    operand_b,
    input  logic [ADDR_W-1:0]              write_pointer,
    input  logic [ADDR_W-1:0]              read_pointer,
    output logic [3:0]                     instr_opc,
    output logic signed [OPERAND_W-1:0]    instr_op_a,
    output logic signed [OPERAND_W-1:0]    instr_op_b,
    output logic signed [2*OPERAND_W-1:0]  instr_result,
    output logic                           instr_valid,
    output logic                           instr_err,
    output logic [CNT_W-1:0]               num_valid
);

    typedef logic signed [OPERAND_W-1:0]   operand_t;
    typedef logic signed [2*OPERAND_W-1:0] result_t;

    typedef struct packed {
        logic [3:0] opc;
        operand_t   op_a;
        operand_t   op_b;
        result_t    result;
        logic       valid;
        logic       err;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    entry_t mem [DEPTH];

    opcode_t           opc_p1;
    operand_t          a_p1;
    operand_t          b_p1;
    logic [ADDR_W-1:0] ptr_p1;
    logic              vld_p1;

    result_t alu_result;
    logic    alu_err;
    entry_t  rd_entry;

    // ---- stage 1: capture request ----

    // Stage-1 valid; a clear in the same cycle drops the incoming request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_p1 <= 1'b0;
        else          vld_p1 <= load_en & ~clear_all;
    end

    // Stage-1 payload; only meaningful while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (load_en) begin
            opc_p1 <= opcode;
            a_p1   <= operand_a;
            b_p1   <= operand_b;
            ptr_p1 <= write_pointer;
        end
    end

    // ---- stage 2: compute and write entry ----

    instr_alu #(
        .OPERAND_W (OPERAND_W)
    ) u_alu (
        .opcode    (opc_p1),
        .operand_a (a_p1),
        .operand_b (b_p1),
        .result    (alu_result),
        .err       (alu_err)
    );

    // Entry storage; clear invalidates everything and wins over a pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear_all) begin
            for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
        end else if (vld_p1) begin
            mem[ptr_p1] <= '{opc:    opc_p1,
                             op_a:   a_p1,
                             op_b:   b_p1,
                             result: alu_result,
                             valid:  1'b1,
                             err:    alu_err};
        end
    end

    // Occupancy: counts only first writes to invalid entries, so it caps at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              num_valid <= '0;
        else if (clear_all)                        num_valid <= '0;
        else if (vld_p1 && !mem[ptr_p1].valid)     num_valid <= num_valid + CNT_ONE;
    end

    // ---- read port ----

    // Invalid entries read back as all-zero.
    always_comb begin
        rd_entry = mem[read_pointer];
        if (!rd_entry.valid) rd_entry = '0;
    end

    // Registered read of the storage as it stood before this edge's write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_opc    <= '0;
            instr_op_a   <= '0;
            instr_op_b   <= '0;
            instr_result <= '0;
            instr_valid  <= 1'b0;
            instr_err    <= 1'b0;
        end else begin
            instr_opc    <= rd_entry.opc;
            instr_op_a   <= rd_entry.op_a;
            instr_op_b   <= rd_entry.op_b;
            instr_result <= rd_entry.result;
            instr_valid  <= rd_entry.valid;
            instr_err    <= rd_entry.err;
        end
    end

endmodule

// File: tb/tb_instr_register_param.sv
// Self-checking bench for instr_register_param: directed scenarios with
// literal expectations plus a randomized run against a behavioural model.
module tb_instr_register_param;
    import instr_register_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    load_en = 1'b0;
    logic                    clear_all = 1'b0;
    opcode_t                 opcode = ZERO;
    logic signed [W-1:0]     operand_a = '0;
    logic signed [W-1:0]     operand_b = '0;
    logic [AW-1:0]           write_pointer = '0;
    logic [AW-1:0]           read_pointer = '0;
    logic [3:0]              instr_opc;
    logic signed [W-1:0]     instr_op_a;
    logic signed [W-1:0]     instr_op_b;
    logic signed [2*W-1:0]   instr_result;
    logic                    instr_valid;
    logic                    instr_err;
    logic [CW-1:0]           num_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    instr_register_param dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_en       (load_en),
        .clear_all     (clear_all),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .write_pointer (write_pointer),
        .read_pointer  (read_pointer),
        .instr_opc     (instr_opc),
        .instr_op_a    (instr_op_a),
        .instr_op_b    (instr_op_b),
        .instr_result  (instr_result),
        .instr_valid   (instr_valid),
        .instr_err     (instr_err),
        .num_valid     (num_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] mo [DEPTH];
    int         ma [DEPTH];
    int         mb [DEPTH];
    longint     mr [DEPTH];
    bit         mv [DEPTH];
    bit         me [DEPTH];

    // request accepted at the previous edge, lands at the next one
    bit         p_v;
    int         p_ptr;
    logic [3:0] p_opc;
    int         p_a, p_b;
    longint     p_r;
    bit         p_e;

    logic [3:0] e_opc;
    int         e_a, e_b;
    longint     e_res;
    bit         e_valid, e_err;
    int         e_nv;

    function automatic void alu_model(input logic [3:0] op, input longint a, input longint b,
                                      output longint r, output bit e);
        r = 0;
        e = 1'b0;
        case (op)
            4'd0: r = 0;
            4'd1: r = a;
            4'd2: r = b;
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd5: r = a * b;
            4'd6: if (b == 0) e = 1'b1; else r = a / b;
            4'd7: if (b == 0) e = 1'b1; else r = a % b;
            default: e = 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mo[i] = 0; ma[i] = 0; mb[i] = 0; mr[i] = 0; mv[i] = 0; me[i] = 0;
        end
        p_v = 0;
        e_opc = 0; e_a = 0; e_b = 0; e_res = 0; e_valid = 0; e_err = 0; e_nv = 0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            int rp;
            int cnt;
            rp = int'(read_pointer);
            if (mv[rp]) begin
                e_opc = mo[rp]; e_a = ma[rp]; e_b = mb[rp]; e_res = mr[rp];
                e_valid = 1; e_err = me[rp];
            end else begin
                e_opc = 0; e_a = 0; e_b = 0; e_res = 0; e_valid = 0; e_err = 0;
            end
            if (clear_all) begin
                for (int i = 0; i < DEPTH; i++) mv[i] = 0;
            end else if (p_v) begin
                mo[p_ptr] = p_opc; ma[p_ptr] = p_a; mb[p_ptr] = p_b;
                mr[p_ptr] = p_r; me[p_ptr] = p_e; mv[p_ptr] = 1;
            end
            p_v = load_en && !clear_all;
            if (load_en) begin
                p_ptr = int'(write_pointer);
                p_opc = opcode;
                p_a   = operand_a;
                p_b   = operand_b;
                alu_model(opcode, longint'(operand_a), longint'(operand_b), p_r, p_e);
            end
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) cnt += mv[i];
            e_nv = cnt;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (instr_opc !== e_opc || instr_op_a !== e_a || instr_op_b !== e_b ||
                instr_result !== e_res || instr_valid !== e_valid || instr_err !== e_err ||
                int'(num_valid) != e_nv) begin
                errors++;
                $display("FAIL model_cmp t=%0t got opc=%h a=%0d b=%0d res=%0d v=%0b e=%0b nv=%0d want opc=%h a=%0d b=%0d res=%0d v=%0b e=%0b nv=%0d",
                         $time, instr_opc, instr_op_a, instr_op_b, instr_result, instr_valid,
                         instr_err, num_valid, e_opc, e_a, e_b, e_res, e_valid, e_err, e_nv);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_wr(input logic [3:0] op, input logic signed [W-1:0] a,
                          input logic signed [W-1:0] b, input int ptr);
        load_en       = 1'b1;
        opcode        = opcode_t'(op);
        operand_a     = a;
        operand_b     = b;
        write_pointer = AW'(ptr);
    endtask

    task automatic wr_and_read(input string name, input logic [3:0] op,
                               input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                               input int ptr, input logic [63:0] exp_res, input bit exp_err);
        set_wr(op, a, b, ptr);
        read_pointer = AW'(ptr);
        tick();
        load_en = 1'b0;
        tick();
        tick();
        check({name, "_res"}, instr_result, exp_res);
        check({name, "_err"}, 64'(instr_err), 64'(exp_err));
    endtask

    function automatic logic signed [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return -1;
            2: return 32'sh8000_0000;
            3: return 1;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // reset contents
        for (int i = 0; i < DEPTH; i++) begin
            read_pointer = AW'(i);
            tick();
            check("reset_valid", 64'(instr_valid), 64'd0);
            check("reset_nv", 64'(num_valid), 64'd0);
        end
        check("reset_result", instr_result, 64'd0);

        // ADD latency
        set_wr(4'd3, 7, -3, 5);
        read_pointer = 5;
        tick();
        load_en = 1'b0;
        tick();
        check("add_e1_valid", 64'(instr_valid), 64'd0);
        tick();
        check("add_e2_res", instr_result, 64'd4);
        check("add_e2_valid", 64'(instr_valid), 64'd1);
        check("add_e2_nv", 64'(num_valid), 64'd1);

        wr_and_read("mult", 4'd5, 32'sh7FFF_FFFF, 2, 6, 64'h0000_0000_FFFF_FFFE, 1'b0);
        wr_and_read("div", 4'd6, -7, 2, 7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        wr_and_read("mod", 4'd7, -7, 2, 8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wr_and_read("div0", 4'd6, 100, 0, 9, 64'd0, 1'b1);
        wr_and_read("illegal", 4'hC, 5, 6, 10, 64'd0, 1'b1);
        wr_and_read("minneg", 4'd6, 32'sh8000_0000, -1, 11, 64'h0000_0000_8000_0000, 1'b0);

        // fill every entry, then overwrite one
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(4'd3, $urandom, $urandom, i);
            tick();
        end
        load_en = 1'b0;
        tick();
        tick();
        check("fill_nv", 64'(num_valid), 64'd32);
        set_wr(4'd1, 99, 0, 3);
        tick();
        load_en = 1'b0;
        tick();
        tick();
        check("rewrite_nv", 64'(num_valid), 64'd32);

        // clear with one write in stage 2 and one being requested
        set_wr(4'd3, 1, 2, 6);
        read_pointer = 3;
        tick();
        set_wr(4'd3, 3, 4, 4);
        clear_all = 1'b1;
        tick();
        check("clear_preread_valid", 64'(instr_valid), 64'd1);
        check("clear_preread_res", instr_result, 64'd99);
        check("clear_nv", 64'(num_valid), 64'd0);
        load_en = 1'b0;
        clear_all = 1'b0;
        read_pointer = 4;
        tick();
        check("clear_ptr4_valid", 64'(instr_valid), 64'd0);
        read_pointer = 6;
        tick();
        check("clear_ptr6_valid", 64'(instr_valid), 64'd0);
        tick();
        check("clear_nv_after", 64'(num_valid), 64'd0);

        // back-to-back writes to one pointer
        set_wr(4'd3, 1, 1, 9);
        tick();
        set_wr(4'd3, 10, 20, 9);
        tick();
        load_en = 1'b0;
        read_pointer = 9;
        tick();
        tick();
        check("b2b_res", instr_result, 64'd30);
        check("b2b_nv", 64'(num_valid), 64'd1);

        // reset while a write sits in stage 1
        set_wr(4'd3, 5, 5, 12);
        read_pointer = 9;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_res", instr_result, 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_nv", 64'(num_valid), 64'd0);
        load_en = 1'b0;
        tick();
        reset_n = 1'b1;
        read_pointer = 12;
        tick();
        tick();
        check("rst_ptr12_valid", 64'(instr_valid), 64'd0);
        check("rst_nv_after", 64'(num_valid), 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            load_en       = ($urandom_range(0, 3) != 0);
            clear_all     = ($urandom_range(0, 59) == 0);
            opcode        = opcode_t'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 15)
                                                                  : $urandom_range(0, 7));
            operand_a     = rand_operand();
            operand_b     = rand_operand();
            write_pointer = AW'($urandom);
            read_pointer  = AW'($urandom);
            tick();
        end
        load_en   = 1'b0;
        clear_all = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
